snoop_responder: RTL
====================

# snoop_responder

Per-cache snoop controller at the receiving end of the shared MESI bus. It watches the registered broadcast (`cmd_out`, `addr_out`, `bus_owner`) from the bus arbiter and ignores transactions its own cache issued. For each foreign transaction it looks up a shadow tag/state array and applies the snoop-side MESI transition. It asserts `snoop_shared` and requests a dirty-line flush from its cache when required.

## Interface
- `CACHE_ID`, default 0: which `bus_owner` bit belongs to this cache (0 or 1).
- `LINES`, default 4: number of direct-mapped lines (power of 2). Index is `addr[log2(LINES)-1:0]`; the tag is the remaining upper address bits.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `cmd_out`  in  bus_request  broadcast command (mesi_types: `No_OP`, `BusRd`, `BusRdX`, `BusUpgr`).
- `addr_out`  in  8  broadcast address.
- `bus_owner`  in  2  one-hot issuer; bit `CACHE_ID` set means the transaction is our own.
- `upd_valid`  in  1  local cache writes one array entry.
- `upd_addr`  in  8  address of the local update.
- `upd_state`  in  2  new MESI state: I=00, S=01, E=10, M=11.
- `upd_ready`  out  1  local update accepted when `upd_valid & upd_ready`.
- `snoop_busy`  out  1  FSM is not in IDLE.
- `snoop_shared`  out  1  one-cycle pulse: the line was present in S/E/M on a `BusRd`.
- `flush_req`  out  1  request to the cache to write back the dirty line.
- `flush_addr`  out  8  address to flush, valid while `flush_req` is high.
- `flush_ack`  in  1  cache has completed the writeback.
- `snoop_done`  out  1  one-cycle pulse: snoop transaction finished.
- `proto_err`  out  1  one-cycle pulse: `BusUpgr` hit a line in E or M.

## Operation
- **Storage:** `LINES` entries, each holding a tag and a 2-bit state. Reset sets every entry to I, tag 0.
- **States:** IDLE, LOOKUP, FLUSH.
- **IDLE:** a transaction is captured when `cmd_out != No_OP` and `bus_owner[CACHE_ID] == 0`. Capture latches cmd and addr and moves to LOOKUP. Otherwise the FSM stays in IDLE.
- **LOOKUP:** hit means `entry.state != I` and `entry.tag == addr` tag.
  - Miss: no state change, go to IDLE, pulse `snoop_done`.
  - `BusRd`, hit M: M->S, pulse `snoop_shared`, go to FLUSH.
  - `BusRd`, hit E: E->S, pulse `snoop_shared`, go to IDLE.
  - `BusRd`, hit S: stays S, pulse `snoop_shared`, go to IDLE.
  - `BusRdX`, hit M: M->I, go to FLUSH.
  - `BusRdX`, hit E or S: ->I, go to IDLE.
  - `BusUpgr`, hit S: S->I, go to IDLE.
  - `BusUpgr`, hit E or M: ->I, pulse `proto_err`, go to IDLE. No flush.
- **FLUSH:** `flush_req=1` and `flush_addr` = captured addr, held stable. When `flush_ack` is sampled high, go to IDLE, drop `flush_req`, pulse `snoop_done`.
- **Local updates:** `upd_ready = (state == IDLE)`. An accepted update writes tag and `upd_state` at the edge.
  - In IDLE, a local update and a capture in the same cycle are both taken.
  - The update is written first; the snoop lookup in the next cycle sees the new entry.
- **Foreign transactions while busy:** dropped. The arbiter re-broadcasts held requests every cycle, and snoop transitions are idempotent (a repeated `BusRd` on S pulses shared again; a repeat after invalidation misses).
- **Own transactions:** `bus_owner[CACHE_ID]=1` is never captured.
- `bus_owner=00` with `cmd_out != No_OP` is treated as foreign.

## Timing
- **Reset values:** all outputs 0 except `upd_ready=1`. The FSM is in IDLE and the array is all I.
- **Reset mid-FLUSH:** abandons the flush; `flush_req` drops asynchronously.
- **Latency, no-flush path:** broadcast in cycle 0 is captured at the end of cycle 0. Cycle 1 is LOOKUP; the array is written at the end of cycle 1. `snoop_shared`, `snoop_done` and `proto_err` are high in cycle 2 only. Capture is possible again in cycle 2.
- **Latency, flush path:** `flush_req` is high from cycle 2. If `flush_ack` is seen in cycle k, `flush_req` is low and `snoop_done` high in cycle k+1, and the FSM is in IDLE in cycle k+1.
- A `flush_ack` already high in cycle 2 ends FLUSH after one cycle. `flush_ack` outside FLUSH is ignored.
- **Register timing:** all outputs are registered except `upd_ready` and `snoop_busy`, which decode the current state.

## Test plan
- **Foreign BusRd on M:** preload addr 0x15 in M via the update port. Drive `BusRd`/0x15 with `bus_owner=10` (`CACHE_ID=0`).
  - Cycle 2: `snoop_shared=1`, `flush_req=1`, `flush_addr=0x15`.
  - Hold `flush_ack=0` for 3 cycles, then 1: `snoop_done` pulses once, and the entry reads S.
- **Own transaction ignored:** `BusRdX`/0x15 with `bus_owner=01` causes no capture and `snoop_busy` stays 0. The same transaction with `bus_owner=10` sets the entry to I with no flush.
- **Tag miss:** entry index 1 holds tag of 0x05 in E. `BusRd`/0x45 gives no `snoop_shared`, `snoop_done` in cycle 2, and the entry stays E.
- **BusUpgr protocol error:** `BusUpgr` on an E line gives `proto_err` and `snoop_done` in cycle 2, and the entry goes to I. The same command on an S line gives I with no `proto_err`.
- **Local update gating:** `upd_valid` during LOOKUP/FLUSH has `upd_ready=0` and no write. A simultaneous update and capture in IDLE applies the update first, so the lookup hits the new state.
- **Reset in FLUSH:** `rst` raised while `flush_req=1` forces all outputs to their reset values immediately, and all entries read I.

Source files
------------

// File: rtl/snoop_responder.sv
// Snoop-side MESI controller: watches the arbiter's registered broadcast, looks up a
// shadow tag/state array and applies the snoop transition, requesting flushes of dirty lines.
package mesi_types;
  typedef enum logic [1:0] {
    No_OP   = 2'b00,
    BusRd   = 2'b01,
    BusRdX  = 2'b10,
    BusUpgr = 2'b11
  } bus_request;
endpackage

module snoop_responder
  import mesi_types::*;
#(
  parameter int unsigned CACHE_ID = 0,
  parameter int unsigned LINES    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  bus_request cmd_out,
  input  logic [7:0] addr_out,
  input  logic [1:0] bus_owner,
  input  logic       upd_valid,
  input  logic [7:0] upd_addr,
  input  logic [1:0] upd_state,
  output logic       upd_ready,
  output logic       snoop_busy,
  output logic       snoop_shared,
  output logic       flush_req,
  output logic [7:0] flush_addr,
  input  logic       flush_ack,
  output logic       snoop_done,
  output logic       proto_err
);
  localparam int unsigned IW = $clog2(LINES);
  localparam int unsigned TW = 8 - IW;

  typedef enum logic [1:0] {IDLE, LOOKUP, FLUSH} state_t;
  typedef enum logic [1:0] {ST_I = 2'b00, ST_S = 2'b01, ST_E = 2'b10, ST_M = 2'b11} mesi_t;

  state_t     r_state, w_nstate;
  bus_request r_cmd;
  logic [7:0] r_addr;
  mesi_t      r_st  [LINES];
  logic [TW-1:0] r_tag [LINES];

  logic          r_shared, r_done, r_perr, r_flush_req;
  logic [7:0]    r_flush_addr;

  logic          w_capture, w_upd_en, w_hit;
  logic          w_shared, w_done, w_perr, w_wr;
  mesi_t         w_wr_st, w_cur_st;
  logic [IW-1:0] w_idx, w_upd_idx;

  assign w_capture = (cmd_out != No_OP) && !bus_owner[CACHE_ID];
  assign w_upd_en  = upd_valid && (r_state == IDLE);
  assign w_idx     = r_addr[IW-1:0];
  assign w_upd_idx = upd_addr[IW-1:0];
  assign w_cur_st  = r_st[w_idx];
  assign w_hit     = (w_cur_st != ST_I) && (r_tag[w_idx] == r_addr[7:IW]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_nstate;
  end

  always_comb begin
    w_nstate = r_state;
    w_shared = 1'b0;
    w_done   = 1'b0;
    w_perr   = 1'b0;
    w_wr     = 1'b0;
    w_wr_st  = ST_I;
    unique case (r_state)
      IDLE: if (w_capture) w_nstate = LOOKUP;
      LOOKUP: begin
        w_nstate = IDLE;
        if (!w_hit) begin
          w_done = 1'b1;
        end else begin
          w_wr = 1'b1;
          case (r_cmd)
            BusRd: begin
              w_wr_st  = ST_S;
              w_shared = 1'b1;
              if (w_cur_st == ST_M) w_nstate = FLUSH;
              else                  w_done   = 1'b1;
            end
            BusRdX: begin
              if (w_cur_st == ST_M) w_nstate = FLUSH;
              else                  w_done   = 1'b1;
            end
            BusUpgr: begin
              w_perr = (w_cur_st == ST_E) || (w_cur_st == ST_M);
              w_done = 1'b1;
            end
            default: begin
              w_wr   = 1'b0;
              w_done = 1'b1;
            end
          endcase
        end
      end
      FLUSH: begin
        if (flush_ack) begin
          w_nstate = IDLE;
          w_done   = 1'b1;
        end
      end
      default: w_nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cmd        <= No_OP;
      r_addr       <= '0;
      r_shared     <= 1'b0;
      r_done       <= 1'b0;
      r_perr       <= 1'b0;
      r_flush_req  <= 1'b0;
      r_flush_addr <= '0;
    end else begin
      if (r_state == IDLE && w_capture) begin
        r_cmd  <= cmd_out;
        r_addr <= addr_out;
      end
      r_shared    <= w_shared;
      r_done      <= w_done;
      r_perr      <= w_perr;
      r_flush_req <= (w_nstate == FLUSH);
      if (r_state == LOOKUP && w_nstate == FLUSH) r_flush_addr <= r_addr;
    end
  end

  // Local updates only land in IDLE and lookup writes only in LOOKUP, so the two never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LINES; i++) begin
        r_st[i]  <= ST_I;
        r_tag[i] <= '0;
      end
    end else if (w_upd_en) begin
      r_st[w_upd_idx]  <= mesi_t'(upd_state);
      r_tag[w_upd_idx] <= upd_addr[7:IW];
    end else if (w_wr) begin
      r_st[w_idx] <= w_wr_st;
    end
  end

  assign upd_ready    = (r_state == IDLE);
  assign snoop_busy   = (r_state != IDLE);
  assign snoop_shared = r_shared;
  assign snoop_done   = r_done;
  assign proto_err    = r_perr;
  assign flush_req    = r_flush_req;
  assign flush_addr   = r_flush_addr;
endmodule
